// File: rtl/basys_mem_initiator.sv
// Button-driven memory initiator: conditions five async buttons into press pulses
// and issues single-word read/write handshakes to a memory responder.

module basys_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module basys_mem_initiator #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] SW,
    input  logic [4:0]  BTN,
    output logic [15:0] LED,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    logic [4:0]    pulse;
    state_t        state, state_n;
    logic [3:0]    addr, addr_n;
    logic [3:0]    xfer_addr, xfer_addr_n;
    logic [15:0]   wdata, wdata_n;
    logic [15:0]   led, led_n;
    logic [TW-1:0] timer, timer_n;

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_btn
            basys_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
                .clk  (CLK),
                .rst  (RST),
                .raw  (BTN[i]),
                .pulse(pulse[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            xfer_addr <= '0;
            wdata     <= '0;
            led       <= '0;
            timer     <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            xfer_addr <= xfer_addr_n;
            wdata     <= wdata_n;
            led       <= led_n;
            timer     <= timer_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        xfer_addr_n = xfer_addr;
        wdata_n     = wdata;
        led_n       = led;
        timer_n     = timer;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (pulse[0]) begin
                    state_n     = WRITE;
                    xfer_addr_n = addr;
                    wdata_n     = SW;
                end else if (pulse[1]) begin
                    state_n     = READ;
                    xfer_addr_n = addr;
                end else if (pulse[4]) begin
                    addr_n = '0;
                end else if (pulse[2]) begin
                    addr_n = addr + 4'd1;
                end else if (pulse[3]) begin
                    addr_n = addr - 4'd1;
                end
            end
            WRITE, READ: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    state_n = IDLE;
                    if (state == READ) led_n = mem_rdata;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = IDLE;
                    led_n   = 16'hDEAD;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request outputs decode straight from the async-reset state so a reset drops them at once.
    assign mem_req   = (state != IDLE);
    assign mem_we    = (state == WRITE);
    assign mem_addr  = xfer_addr;
    assign mem_wdata = (state == WRITE) ? wdata : 16'h0000;
    assign LED       = led;
endmodule

// File: tb/tb_basys_mem_initiator.sv
// Scoreboard bench for basys_mem_initiator: stimulus queues expected transactions,
// a monitor checks each request and its hold behaviour, a model responder acks.

module tb_basys_mem_initiator;
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] SW;
    logic [4:0]  BTN;
    logic [15:0] LED;
    logic        mem_req, mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    basys_mem_initiator dut (
        .CLK(CLK), .RST(RST), .SW(SW), .BTN(BTN), .LED(LED),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic        resp_en;
    int          ack_delay = 2;
    logic [15:0] rd_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic we, input logic [3:0] a, input logic [15:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic cycles(input int k);
        repeat (k) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (mem_req !== 1'b1 && n < 60) begin @(posedge CLK); #1; n++; end
        if (mem_req !== 1'b1) check("req_rise_timeout", 32'(mem_req), 1);
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (mem_req !== 1'b0 && n < 60) begin @(posedge CLK); #1; n++; end
        if (mem_req !== 1'b0) check("req_fall_timeout", 32'(mem_req), 0);
    endtask

    task automatic start_txn(input logic [4:0] mask, output int lat, output int hi);
        BTN = mask;
        wait_rise(lat);
        wait_fall(hi);
    endtask

    task automatic release_btn(input int hold);
        cycles(hold);
        BTN = '0;
        cycles(10);
    endtask

    task automatic press_only(input logic [4:0] mask);
        BTN = mask;
        cycles(10);
        BTN = '0;
        cycles(10);
    endtask

    // Model responder: ack one cycle, ack_delay cycles after request appears.
    initial begin
        int age;
        age = 0;
        forever begin
            @(posedge CLK); #1;
            if (mem_req === 1'b1 && mem_ack !== 1'b1) begin
                age++;
                if (resp_en && age == ack_delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_val;
                end
            end else begin
                if (resp_en) mem_ack = 1'b0;
                age = 0;
            end
        end
    end

    // Monitor: pops an expectation at each request start, then checks hold and idle-zero.
    initial begin
        logic        prev;
        logic        c_we;
        logic [3:0]  c_addr;
        logic [15:0] c_wdata;
        txn_t        e;
        prev = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        forever begin
            @(posedge CLK); #1;
            if (RST !== 1'b0) begin
                prev = 1'b0;
            end else begin
                if (mem_req === 1'b1 && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", {mem_we, 11'd0, mem_addr, mem_wdata}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_we", 32'(mem_we), 32'(e.we));
                        check("txn_addr", 32'(mem_addr), 32'(e.addr));
                        if (e.we) check("txn_wdata", 32'(mem_wdata), 32'(e.wdata));
                    end
                    c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
                end else if (mem_req === 1'b1) begin
                    check("txn_hold", 32'({mem_we, mem_addr, mem_wdata}), 32'({c_we, c_addr, c_wdata}));
                end else begin
                    check("idle_zero", 32'({mem_we, mem_wdata}), 0);
                end
                prev = (mem_req === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hi;
        RST = 1'b1; SW = '0; BTN = '0; mem_ack = 1'b0; mem_rdata = '0;
        resp_en = 1'b1; rd_val = '0;
        cycles(3);
        check("rst_led", 32'(LED), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        RST = 1'b0;
        cycles(3);

        // Held write button: one write, 8 edges from raw press to request.
        SW = 16'h5555;
        expect_txn(1'b1, 4'h0, 16'h5555);
        start_txn(5'b00001, lat, hi);
        check("write_latency", 32'(lat), 8);
        check("write_req_len", 32'(hi), 3);
        check("write_led", 32'(LED), 0);
        release_btn(20);

        // Read back into LED on the cycle after ack.
        rd_val = 16'h5555; SW = 16'h0000;
        expect_txn(1'b0, 4'h0, 16'h0);
        start_txn(5'b00010, lat, hi);
        check("read_req_len", 32'(hi), 3);
        check("read_led", 32'(LED), 32'h5555);
        release_btn(4);

        // Decrement wraps to F, then two increments wrap to 1.
        press_only(5'b01000);
        rd_val = 16'h1234;
        expect_txn(1'b0, 4'hF, 16'h0);
        start_txn(5'b00010, lat, hi);
        check("read_f_led", 32'(LED), 32'h1234);
        release_btn(4);
        press_only(5'b00100);
        press_only(5'b00100);
        SW = 16'hA5A5;
        expect_txn(1'b1, 4'h1, 16'hA5A5);
        start_txn(5'b00001, lat, hi);
        check("write_keeps_led", 32'(LED), 32'h1234);
        release_btn(4);

        // Bouncing button: one write, latency counted from last edge of bounce.
        SW = 16'h0F0F;
        expect_txn(1'b1, 4'h1, 16'h0F0F);
        BTN = 5'b00001; cycles(1);
        BTN = 5'b00000; cycles(1);
        BTN = 5'b00001; cycles(1);
        BTN = 5'b00000; cycles(1);
        BTN = 5'b00001;
        wait_rise(lat);
        check("bounce_latency", 32'(lat), 8);
        wait_fall(hi);
        release_btn(4);

        // Simultaneous read + decrement: read wins, decrement dropped.
        rd_val = 16'h4321;
        expect_txn(1'b0, 4'h1, 16'h0);
        start_txn(5'b01010, lat, hi);
        check("prio_led", 32'(LED), 32'h4321);
        release_btn(4);

        // Timeout with silent responder, then a normal read.
        resp_en = 1'b0;
        expect_txn(1'b0, 4'h1, 16'h0);
        start_txn(5'b00010, lat, hi);
        check("timeout_req_len", 32'(hi), 15);
        check("timeout_led", 32'(LED), 32'hDEAD);
        release_btn(4);
        resp_en = 1'b1; rd_val = 16'hBEEF;
        expect_txn(1'b0, 4'h1, 16'h0);
        start_txn(5'b00010, lat, hi);
        check("after_timeout_led", 32'(LED), 32'hBEEF);
        release_btn(4);

        // Reset mid-write aborts without a clock edge; late ack ignored.
        resp_en = 1'b0; SW = 16'hCAFE;
        expect_txn(1'b1, 4'h1, 16'hCAFE);
        BTN = 5'b00001;
        wait_rise(lat);
        cycles(2);
        #2 RST = 1'b1;
        #1;
        check("abort_req", 32'(mem_req), 0);
        check("abort_we", 32'(mem_we), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_wdata", 32'(mem_wdata), 0);
        check("abort_led", 32'(LED), 0);
        BTN = '0;
        cycles(2);
        RST = 1'b0;
        cycles(2);
        mem_ack = 1'b1;
        cycles(1);
        mem_ack = 1'b0;
        cycles(3);
        check("late_ack_req", 32'(mem_req), 0);
        check("late_ack_led", 32'(LED), 0);
        resp_en = 1'b1; rd_val = 16'h7777;
        expect_txn(1'b0, 4'h0, 16'h0);
        start_txn(5'b00010, lat, hi);
        check("post_reset_latency", 32'(lat), 8);
        check("post_reset_led", 32'(LED), 32'h7777);
        release_btn(4);

        cycles(5);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
